bilateral_norm_acc: RTL
=======================

Name: bilateral_norm_acc

Overview:
- Consumer end of the per-tap weight pipeline.
- Each tap delivers a weighted pixel `w*a` (16 bit) and its weight `w` (8 bit).
- The block accumulates NTAPS taps per output pixel, then runs a sequential restoring divider to compute `sum(w*a) / sum(w)`.
- Emits the 8-bit filtered pixel over a valid/ready handshake toward the video output stage.

Parameters:
- NTAPS, 9, taps per output pixel; legal range 2..16.
- WP_W, 20, weighted-pixel accumulator width; must be ≥ 16 + ceil(log2 NTAPS).
- W_W, 12, weight accumulator width; must be ≥ 8 + ceil(log2 NTAPS).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  tap present.
- in_ready  out  1  block accepts tap; a tap transfers when in_valid & in_ready.
- in_wpix  in  16  weighted pixel w*a.
- in_weight  in  8  tap weight w.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts result.
- out_pix  out  8  normalized pixel.
- out_zero  out  1  sum of weights was 0 for this result.
- out_sat  out  1  quotient overflowed 8 bits and was clamped to 255.

Behaviour:
- Reset (async) values:
  - state = ACC, tap counter = 0, both accumulators = 0.
  - in_ready = 1, out_valid = 0, out_pix = 0, out_zero = 0, out_sat = 0.
- FSM states ACC, DIV, OUT.
- ACC state:
  - in_ready = 1.
  - Each transfer adds in_wpix (zero-extended) to SWP and in_weight to SW, and increments the tap counter.
  - The transfer that makes the count equal NTAPS loads the divider and moves to DIV; its own tap is included in the sums.
  - The tap counter resets to 0 on that transfer.
- DIV state:
  - in_ready = 0.
  - Dividend D = SWP (plus rounding term, see Optional Feature). Divisor S = SW.
  - First DIV cycle handles two special cases, each then going directly to OUT:
    - S == 0: out_pix = 0, out_zero = 1.
    - D ≥ S<<8: out_pix = 255, out_sat = 1.
  - Otherwise, 8 iterations, one per clock, i = 7 down to 0: if R ≥ (S<<i) then R -= S<<i and q[i] = 1; R starts at D.
  - After iteration i = 0: register q into out_pix and go to OUT.
  - Accumulators clear when DIV is entered.
- Latency:
  - Normal case: out_valid rises on the 8th clock edge after the edge that accepted the final tap.
  - Zero and saturation cases: out_valid rises on the 1st edge after that acceptance edge.
- OUT state:
  - out_valid = 1; out_pix, out_zero and out_sat are held stable until out_valid & out_ready.
  - in_ready = 0.
  - On acceptance: out_valid = 0, flags clear, next state ACC, and in_ready = 1 on the following cycle.
  - out_pix keeps its last value after acceptance.
- Boundary conditions:
  - out_ready may be held high permanently; the throughput bound is then NTAPS + 9 cycles per result.
  - in_valid arriving while in_ready = 0 is ignored; it is neither consumed nor stalled internally.
  - in_valid toggling mid-group keeps the partial count and sums, with no timeout.
  - Accumulators are sized so they cannot overflow for legal parameters; no wrap handling is required.
  - A reset asserted in any state returns immediately to reset values; a partial group is discarded and a pending result is dropped.
- Arithmetic: all unsigned; the quotient truncates unless ROUND_EN is defined.

Optional Feature:
- Macro BILATERAL_NORM_ROUND_EN.
- Defined: D = SWP + (SW >> 1), giving round-half-up to nearest. The saturation test uses this rounded D.
- Undefined: D = SWP, giving a truncated quotient.
- Latency and handshake are identical in both builds.

Test Plan:
- Uniform taps: 9 taps each in_wpix = 25400, in_weight = 254 (a = 100).
  - Expected sums: SWP = 228600, SW = 2286.
  - Required: out_pix = 100, out_zero = 0, out_sat = 0, with out_valid exactly 8 clocks after the acceptance edge of the 9th tap.
- Single dominant tap: tap 0 has wpix = 10000, w = 200; the other 8 taps are 0/0 → out_pix = 50.
- All weights zero: 9 taps 0/0 → out_zero = 1, out_pix = 0, out_valid one clock after the last tap.
- Rounding: taps sum to SWP = 10, SW = 4 (tap 0 = 10/4, rest 0/0).
  - Without BILATERAL_NORM_ROUND_EN: out_pix = 2.
  - With BILATERAL_NORM_ROUND_EN: out_pix = 3.
- Saturation and backpressure: SWP = 60000, SW = 200 → out_sat = 1, out_pix = 255.
  - Hold out_ready = 0 for 5 cycles: outputs remain stable, in_ready stays 0, and taps driven meanwhile are not consumed.
  - Release out_ready: next group accepted normally.
- Reset mid-DIV: assert rst_n = 0 during the 4th DIV cycle, then release.
  - All outputs return to reset values and no out_valid appears.
  - A fresh 9-tap group then yields the correct result.

Source files
------------

// File: rtl/bilateral_norm_acc.sv
// Bilateral filter normalizer: accumulates NTAPS weighted taps, then divides sum(w*a) by sum(w)
// with an 8-step restoring divider. Define BILATERAL_NORM_ROUND_EN for round-half-up quotients.
module bilateral_norm_acc #(
  parameter int NTAPS = 9,
  parameter int WP_W  = 20,
  parameter int W_W   = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_wpix,
  input  logic [7:0]  in_weight,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_pix,
  output logic        out_zero,
  output logic        out_sat
);

  localparam int CNT_W = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  // Remainder width covers both the (possibly rounded) dividend and the divisor shifted by 8.
  localparam int RW    = (WP_W + 1 > W_W + 9) ? WP_W + 1 : W_W + 9;

`ifdef BILATERAL_NORM_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  typedef enum logic [1:0] {ACC, DIV, OUT} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] tap_cnt;
  logic [WP_W-1:0]  swp, swp_sum;
  logic [W_W-1:0]   sw, sw_sum;
  logic [RW-1:0]    rem, dvsr, shifted;
  logic [7:0]       quo, q_next;
  logic [2:0]       bit_idx;
  logic             tap_fire, last_tap, first_div, div_zero, div_sat, trial_ok;

  function automatic logic [RW-1:0] dividend(input logic [WP_W-1:0] s_wp,
                                             input logic [W_W-1:0]  s_w);
    logic [RW-1:0] d;
    d = RW'(s_wp) + (ROUND_EN ? RW'(s_w >> 1) : '0);
    return d;
  endfunction

  function automatic logic saturates(input logic [RW-1:0] d, input logic [RW-1:0] s);
    return d >= (s << 8);
  endfunction

  assign in_ready  = (state == ACC);
  assign out_valid = (state == OUT);

  assign tap_fire  = in_valid & in_ready;
  assign last_tap  = tap_fire && (tap_cnt == CNT_W'(NTAPS - 1));
  assign swp_sum   = swp + {{(WP_W-16){1'b0}}, in_wpix};
  assign sw_sum    = sw + {{(W_W-8){1'b0}}, in_weight};

  // bit_idx is 7 only in the first DIV cycle, which doubles as the special-case check.
  assign first_div = (bit_idx == 3'd7);
  assign div_zero  = (dvsr == '0);
  assign div_sat   = saturates(rem, dvsr);
  assign shifted   = dvsr << bit_idx;
  assign trial_ok  = (rem >= shifted);

  always_comb begin
    q_next          = quo;
    q_next[bit_idx] = trial_ok;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACC: if (last_tap) state_nxt = DIV;
      DIV: begin
        if (first_div && (div_zero || div_sat)) state_nxt = OUT;
        else if (bit_idx == 3'd0)               state_nxt = OUT;
      end
      OUT: if (out_ready) state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  // ---- control and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ACC;
      tap_cnt  <= '0;
      swp      <= '0;
      sw       <= '0;
      bit_idx  <= 3'd7;
      out_pix  <= '0;
      out_zero <= 1'b0;
      out_sat  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (tap_fire) begin
        if (last_tap) begin
          tap_cnt <= '0;
          swp     <= '0;
          sw      <= '0;
        end else begin
          tap_cnt <= tap_cnt + CNT_W'(1);
          swp     <= swp_sum;
          sw      <= sw_sum;
        end
      end
      if (last_tap)
        bit_idx <= 3'd7;
      else if (state == DIV)
        bit_idx <= bit_idx - 3'd1;
      if (state == DIV) begin
        if (first_div && div_zero) begin
          out_pix  <= 8'd0;
          out_zero <= 1'b1;
        end else if (first_div && div_sat) begin
          out_pix <= 8'd255;
          out_sat <= 1'b1;
        end else if (bit_idx == 3'd0) begin
          out_pix <= q_next;
        end
      end
      if (state == OUT && out_ready) begin
        out_zero <= 1'b0;
        out_sat  <= 1'b0;
      end
    end
  end

  // ---- divider datapath
  always_ff @(posedge clk) begin
    if (last_tap) begin
      rem  <= dividend(swp_sum, sw_sum);
      dvsr <= RW'(sw_sum);
      quo  <= '0;
    end else if (state == DIV) begin
      quo <= q_next;
      if (trial_ok) rem <= rem - shifted;
    end
  end

endmodule
